mmio_responder: RTL and testbench

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder.sv | 172 +++++++++++++++++
 tb/tb_mmio_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//   Memory-mapped peripheral block in the 0x8xxx_xxxx window of the core's
//   data bus. It provides a 4-deep UART transmit FIFO, a single-byte UART
//   receive holding register, a free-running cycle counter and a retired
//   instruction counter. Load data returns one cycle after the request.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst_n          : asynchronous active-low reset
//   addr           : byte address of the current load/store
//   wdata          : store data
//   mem_wen        : per-byte store enables (any bit set = store)
//   ren            : load in progress this cycle
//   inst_retire    : one-cycle pulse per retired instruction
//   hit            : combinational window decode, addr[31:28] == 4'b1000
//   rdata          : registered load data (0 when no load was decoded)
//   uart_tx_data   : byte at the TX FIFO head
//   uart_tx_valid  : TX FIFO not empty
//   uart_tx_ready  : transmitter accepts the head byte
//   uart_rx_data   : received byte
//   uart_rx_valid  : received byte present
//   uart_rx_ready  : RX holding register empty
//
// Register map (addr[7:0])
//   0x00 R status {30'b0, rx_full, !tx_full}
//   0x04 R rx byte (clears rx_full)
//   0x08 W tx push (byte lane 0)
//   0x10 R cycle counter
//   0x14 R instruction counter
//   0x18 W clear both counters
// -----------------------------------------------------------------------------
module mmio_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mem_wen,
  input  logic        ren,
  input  logic        inst_retire,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int DATA_W = 32;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  logic [7:0]        offset;
  logic              store;
  logic              rd_sel_p0;
  logic [DATA_W-1:0] rd_val_p0;

  logic [7:0]        tx_mem [4];
  logic [2:0]        tx_count;
  logic [1:0]        tx_rd_ptr;
  logic [1:0]        tx_wr_ptr;
  logic              tx_full;
  logic              tx_push;
  logic              tx_pop;

  logic [7:0]        rx_byte;
  logic              rx_full;
  logic              rx_load;
  logic              rx_take;

  logic [DATA_W-1:0] cycle_cnt;
  logic [DATA_W-1:0] instr_cnt;
  logic              cnt_clr;

  assign hit       = (addr[31:28] == 4'b1000);
  assign offset    = addr[7:0];
  assign store     = |mem_wen;
  assign rd_sel_p0 = ren && hit;

  assign tx_full       = (tx_count == 3'd4);
  assign uart_tx_valid = (tx_count != 3'd0);
  assign uart_tx_data  = tx_mem[tx_rd_ptr];
  // Fullness is judged on the count at the start of the cycle, so a push
  // into a full FIFO is dropped even when the head is popped in that cycle.
  assign tx_push       = hit && mem_wen[0] && (offset == OFF_TXDATA) && !tx_full;
  assign tx_pop        = uart_tx_valid && uart_tx_ready;

  assign uart_rx_ready = !rx_full;
  assign rx_load       = uart_rx_valid && !rx_full;
  assign rx_take       = rd_sel_p0 && (offset == OFF_RXDATA);

  assign cnt_clr       = hit && store && (offset == OFF_CLEAR);

  always_comb begin
    rd_val_p0 = '0;
    unique case (offset)
      OFF_STATUS: rd_val_p0 = {30'b0, rx_full, !tx_full};
      OFF_RXDATA: rd_val_p0 = {24'b0, rx_byte};
      OFF_CYCLE:  rd_val_p0 = cycle_cnt;
      OFF_INSTR:  rd_val_p0 = instr_cnt;
      default:    rd_val_p0 = '0;
    endcase
  end

  // ---- p0 -> p1: load data capture -----------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= rd_sel_p0 ? rd_val_p0 : '0;
    end
  end

  // FIFO storage holds data only; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count  <= 3'd0;
      tx_rd_ptr <= 2'd0;
      tx_wr_ptr <= 2'd0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 2'd1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 2'd1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 3'd1;
        2'b01:   tx_count <= tx_count - 3'd1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // A load can only happen while empty, so it never collides with a read
  // that clears a full register; an empty-register read leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full <= 1'b0;
      rx_byte <= 8'd0;
    end else if (rx_load) begin
      rx_full <= 1'b1;
      rx_byte <= uart_rx_data;
    end else if (rx_take) begin
      rx_full <= 1'b0;
    end
  end

  // Clear wins over the same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (inst_retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mem_wen;
  logic        ren;
  logic        inst_retire;
  logic        hit;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  int checks   = 0;
  int failures = 0;

  mmio_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .wdata        (wdata),
    .mem_wen      (mem_wen),
    .ren          (ren),
    .inst_retire  (inst_retire),
    .hit          (hit),
    .rdata        (rdata),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        ren;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    logic        exp_tx_valid;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    addr        = 32'h0;
    wdata       = 32'h0;
    mem_wen     = 4'h0;
    ren         = 1'b0;
    inst_retire = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    addr    = 32'h8000_0008;
    wdata   = {24'h0, b};
    mem_wen = 4'h1;
    step();
    idle();
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] val);
    addr = {24'h800000, off};
    ren  = 1'b1;
    step();
    val = rdata;
    idle();
  endtask

  initial begin
    logic [31:0] v;
    logic [19:0] pat;

    // After reset: count 0, rx empty, rx_byte 0. One row per cycle.
    vecs[0]  = '{32'h8000_0000, 32'h0,  4'h0, 1'b1, 1'b1, 32'h1, 1'b0}; // status
    vecs[1]  = '{32'h8000_0004, 32'h0,  4'h0, 1'b1, 1'b1, 32'h0, 1'b0}; // rx byte
    vecs[2]  = '{32'h8000_000C, 32'h0,  4'h0, 1'b1, 1'b1, 32'h0, 1'b0}; // unmapped
    vecs[3]  = '{32'h9000_0000, 32'h0,  4'h0, 1'b1, 1'b0, 32'h0, 1'b0}; // miss
    vecs[4]  = '{32'h0000_0010, 32'h0,  4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{32'h8000_0020, 32'hFF, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0}; // unmapped wr
    vecs[6]  = '{32'h7000_0008, 32'h99, 4'h1, 1'b0, 1'b0, 32'h0, 1'b0}; // miss push
    vecs[7]  = '{32'h8000_0008, 32'h77, 4'h2, 1'b0, 1'b1, 32'h0, 1'b0}; // lane 1 only
    vecs[8]  = '{32'h8000_0008, 32'h33, 4'h1, 1'b1, 1'b1, 32'h0, 1'b1}; // push + read
    vecs[9]  = '{32'h8000_0000, 32'h0,  4'h0, 1'b1, 1'b1, 32'h1, 1'b1}; // status
    vecs[10] = '{32'h8000_0010, 32'h0,  4'h0, 1'b0, 1'b1, 32'h0, 1'b1}; // no ren

    idle();
    uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    rst_n = 1'b0;
    #12;
    check("reset_rdata",    rdata, 32'h0);
    check("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);

    // ---- table-driven decode / read path ----
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      addr    = vecs[i].addr;
      wdata   = vecs[i].wdata;
      mem_wen = vecs[i].wen;
      ren     = vecs[i].ren;
      #1;
      check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      step();
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_txv", i), {31'b0, uart_tx_valid}, {31'b0, vecs[i].exp_tx_valid});
    end
    idle();
    check("tx_head_33", {24'h0, uart_tx_data}, 32'h33);

    // ---- TX fill, overflow drop, ordered drain ----
    reset_dut();
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    rd(8'h00, v);
    check("status_tx_full", v, 32'h0);
    push(8'h45);
    check("tx_hold_head", {24'h0, uart_tx_data}, 32'h41);
    step();
    check("tx_hold_head2", {24'h0, uart_tx_data}, 32'h41);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), {31'b0, uart_tx_valid}, 32'h1);
      check($sformatf("drain%0d_data", i), {24'h0, uart_tx_data}, 32'h41 + i);
      step();
    end
    check("drain_empty", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // ---- full FIFO: simultaneous pop and push drops the push ----
    reset_dut();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    uart_tx_ready = 1'b1;
    addr = 32'h8000_0008; wdata = 32'h99; mem_wen = 4'h1;
    step();
    idle();
    uart_tx_ready = 1'b0;
    rd(8'h00, v);
    check("full_poppush_status", v, 32'h1);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fpp%0d_data", i), {24'h0, uart_tx_data}, 32'h11 + i);
      step();
    end
    check("fpp_empty", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // ---- two entries: simultaneous pop and push keeps count, order ----
    reset_dut();
    push(8'hA0);
    push(8'hA1);
    uart_tx_ready = 1'b1;
    addr = 32'h8000_0008; wdata = 32'hA2; mem_wen = 4'h1;
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tpp%0d_valid", i), {31'b0, uart_tx_valid}, 32'h1);
      check($sformatf("tpp%0d_data", i), {24'h0, uart_tx_data}, 32'hA1 + i);
      step();
    end
    check("tpp_empty", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // ---- RX holding register (FIFO filled so status bit0 is 0) ----
    reset_dut();
    for (int i = 0; i < 4; i++) push(8'h01);
    uart_rx_data  = 8'h5A;
    uart_rx_valid = 1'b1;
    #1;
    check("rx_ready_before", {31'b0, uart_rx_ready}, 32'h1);
    step();
    uart_rx_valid = 1'b0;
    check("rx_ready_fell", {31'b0, uart_rx_ready}, 32'h0);
    rd(8'h00, v);
    check("rx_status", v, 32'h2);
    rd(8'h04, v);
    check("rx_data", v, 32'h5A);
    check("rx_ready_back", {31'b0, uart_rx_ready}, 32'h1);
    uart_rx_data = 8'hC3;
    rd(8'h04, v);
    check("rx_stale", v, 32'h5A);
    check("rx_stale_ready", {31'b0, uart_rx_ready}, 32'h1);

    // ---- cycle counter and clear ----
    reset_dut();
    repeat (10) step();
    rd(8'h10, v);
    check("cycle_10", v, 32'd10);
    addr = 32'h8000_0018; mem_wen = 4'hF;
    step();
    idle();
    repeat (5) step();
    rd(8'h10, v);
    check("cycle_after_clr", v, 32'd5);

    // ---- instruction counter, clear coincident with retire ----
    reset_dut();
    pat = 20'h888A5;
    for (int i = 0; i < 20; i++) begin
      inst_retire = pat[i];
      step();
    end
    inst_retire = 1'b0;
    rd(8'h14, v);
    check("instr_7", v, 32'd7);
    addr = 32'h8000_0018; mem_wen = 4'h4; inst_retire = 1'b1;
    step();
    idle();
    rd(8'h10, v);
    check("clr_cycle_0", v, 32'd0);
    rd(8'h14, v);
    check("clr_instr_0", v, 32'd0);

    // ---- asynchronous reset mid-operation ----
    reset_dut();
    for (int i = 0; i < 3; i++) push(8'h61 + 8'(i));
    uart_rx_data  = 8'h77;
    uart_rx_valid = 1'b1;
    step();
    uart_rx_valid = 1'b0;
    rd(8'h00, v);
    check("pre_rst_status", v, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("async_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    check("async_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    rd(8'h04, v);
    check("post_rst_rx_byte", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
